// File: rtl/boot_loader_6502.sv
// rtl/boot_loader_6502.sv - UART-fed program loader and CPU reset sequencer for a 6502 subsystem
//
// Holds the 6502 in reset and receives a framed image:
//   0xA5, LEN_HI, LEN_LO, LEN data bytes, CSUM
// Data bytes are written into RAM starting at LoadStart. The frame passes
// when (sum of data bytes + CSUM) mod 256 == 0. After a pass the CPU reset is
// released ReleaseDelay cycles later. Any failure (oversize length, bad
// checksum, inter-byte idle timeout) reports error_o and waits for the next
// magic byte with the CPU still in reset.
//
// Ports:
//   clk_i       in   1  system clock
//   reset_i     in   1  synchronous active-high reset
//   rx_data_i   in   8  received byte
//   rx_valid_i  in   1  one-cycle strobe qualifying rx_data_i
//   ram_addr_o  out 16  RAM byte address of the write
//   ram_data_o  out  8  RAM write data
//   ram_we_o    out  1  RAM write enable, one cycle per data byte
//   cpu_reset_o out  1  CPU/peripheral reset request
//   busy_o      out  1  a frame is in progress
//   done_o      out  1  last load passed, CPU released
//   error_o     out  1  last frame failed (sticky until next magic byte)
module boot_loader_6502 #(
  parameter int unsigned LoadStart     = 'h0200,
  parameter int unsigned RAM_Size      = 4102,
  parameter int unsigned ReleaseDelay  = 16,
  parameter int unsigned TimeoutCycles = 5000000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [15:0] ram_addr_o,
  output logic [7:0]  ram_data_o,
  output logic        ram_we_o,
  output logic        cpu_reset_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam logic [7:0]  Magic  = 8'hA5;
  // Largest image that keeps every write inside [LoadStart, RAM_Size-7].
  localparam int unsigned MaxLen = RAM_Size - 6 - LoadStart;
  // Idle counter only ever holds 0..TimeoutCycles-1.
  localparam int unsigned IdleW    = $clog2(TimeoutCycles);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TimeoutCycles - 1);
  localparam logic [7:0]  RelLast  = 8'(ReleaseDelay - 1);

  typedef enum logic [2:0] {
    S_WAIT_MAGIC,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_RELEASE,
    S_RUN,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       len_hi_q, len_hi_d;
  logic [15:0]      ptr_q, ptr_d;
  logic [15:0]      left_q, left_d;
  logic [7:0]       sum_q, sum_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [7:0]       rel_q, rel_d;

  logic [15:0] addr_d;
  logic [7:0]  data_d;
  logic        we_d, cpu_reset_d, busy_d, done_d, error_d;

  logic        go_error;
  logic [15:0] full_len;
  logic [7:0]  sum_plus_byte;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_WAIT_MAGIC;
      len_hi_q    <= '0;
      ptr_q       <= '0;
      left_q      <= '0;
      sum_q       <= '0;
      idle_q      <= '0;
      rel_q       <= '0;
      ram_addr_o  <= '0;
      ram_data_o  <= '0;
      ram_we_o    <= 1'b0;
      cpu_reset_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      ptr_q       <= ptr_d;
      left_q      <= left_d;
      sum_q       <= sum_d;
      idle_q      <= idle_d;
      rel_q       <= rel_d;
      ram_addr_o  <= addr_d;
      ram_data_o  <= data_d;
      ram_we_o    <= we_d;
      cpu_reset_o <= cpu_reset_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      error_o     <= error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    len_hi_d      = len_hi_q;
    ptr_d         = ptr_q;
    left_d        = left_q;
    sum_d         = sum_q;
    idle_d        = idle_q;
    rel_d         = rel_q;
    addr_d        = ram_addr_o;
    data_d        = ram_data_o;
    we_d          = 1'b0;
    cpu_reset_d   = cpu_reset_o;
    busy_d        = busy_o;
    done_d        = done_o;
    error_d       = error_o;
    go_error      = 1'b0;
    full_len      = {len_hi_q, rx_data_i};
    sum_plus_byte = sum_q + rx_data_i;

    case (state_q)
      // ERROR lasts a single cycle and already listens for the next magic
      // byte, so a frame that follows a failure immediately is not lost.
      S_WAIT_MAGIC, S_ERROR, S_RUN: begin
        if (state_q == S_ERROR) state_d = S_WAIT_MAGIC;
        if (rx_valid_i && rx_data_i == Magic) begin
          state_d     = S_LEN_HI;
          busy_d      = 1'b1;
          error_d     = 1'b0;
          done_d      = 1'b0;
          cpu_reset_d = 1'b1;
          sum_d       = 8'h00;
          idle_d      = '0;
        end
      end

      S_LEN_HI: begin
        if (rx_valid_i) begin
          len_hi_d = rx_data_i;
          state_d  = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (rx_valid_i) begin
          if (32'(full_len) > MaxLen) begin
            go_error = 1'b1;
          end else if (full_len == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
            ptr_d   = 16'(LoadStart);
            left_d  = full_len;
          end
        end
      end

      S_DATA: begin
        if (rx_valid_i) begin
          we_d   = 1'b1;
          addr_d = ptr_q;
          data_d = rx_data_i;
          ptr_d  = ptr_q + 16'd1;
          sum_d  = sum_plus_byte;
          left_d = left_q - 16'd1;
          if (left_q == 16'd1) state_d = S_CSUM;
        end
      end

      S_CSUM: begin
        if (rx_valid_i) begin
          sum_d = sum_plus_byte;
          if (sum_plus_byte == 8'h00) begin
            state_d = S_RELEASE;
            rel_d   = 8'h00;
          end else begin
            go_error = 1'b1;
          end
        end
      end

      S_RELEASE: begin
        if (rel_q == RelLast) begin
          state_d     = S_RUN;
          cpu_reset_d = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
        end else begin
          rel_d = rel_q + 8'd1;
        end
      end

      default: state_d = S_WAIT_MAGIC;
    endcase

    // Inter-byte watchdog inside a frame. A byte arriving on the expiry
    // cycle clears the counter and suppresses the timeout.
    if (state_q inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM}) begin
      if (rx_valid_i) begin
        idle_d = '0;
      end else if (idle_q == IdleLast) begin
        go_error = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end

    if (go_error) begin
      state_d     = S_ERROR;
      error_d     = 1'b1;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      cpu_reset_d = 1'b1;
      idle_d      = '0;
    end
  end

endmodule

// File: tb/tb_boot_loader_6502.sv
// tb/tb_boot_loader_6502.sv - self-checking bench for boot_loader_6502
module tb_boot_loader_6502;

  localparam int LS     = 'h0200;
  localparam int RS     = 4102;
  localparam int RD     = 16;
  localparam int TO     = 100;
  localparam int MAXLEN = RS - 6 - LS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] ram_addr_o;
  logic [7:0]  ram_data_o;
  logic        ram_we_o, cpu_reset_o, busy_o, done_o, error_o;

  int total = 0;
  int bad = 0;

  logic [15:0] got_addr[$];
  logic [7:0]  got_data[$];
  logic [15:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  logic [7:0]  frame_q[$];
  bit          exp_pass;

  boot_loader_6502 #(
    .LoadStart(LS), .RAM_Size(RS), .ReleaseDelay(RD), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .reset_i(reset), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_we_o(ram_we_o),
    .cpu_reset_o(cpu_reset_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  // RAM-side observer: one entry per cycle with the write enable high.
  always begin
    @(posedge clk);
    #2;
    if (ram_we_o === 1'b1) begin
      got_addr.push_back(ram_addr_o);
      got_data.push_back(ram_data_o);
    end
  end

  // Callers sit on a negedge; returns on the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: expected writes and verdict straight from the frame rules.
  function automatic void model();
    int len;
    int s;
    exp_addr.delete();
    exp_data.delete();
    len = int'({frame_q[1], frame_q[2]});
    exp_pass = 1'b0;
    if (len > MAXLEN) return;
    s = 0;
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(16'(LS + i));
      exp_data.push_back(frame_q[3 + i]);
      s += int'(frame_q[3 + i]);
    end
    s += int'(frame_q[3 + len]);
    exp_pass = (s % 256) == 0;
  endfunction

  function automatic int release_wait();
    return 0;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    total++; if (cpu_reset_o !== 1'b1) begin bad++; $display("FAIL reset_cpu_reset got=%b exp=1", cpu_reset_o); end
    total++; if (ram_we_o !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", ram_we_o); end
    total++; if (ram_addr_o !== 16'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", ram_addr_o); end
    total++; if (ram_data_o !== 8'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", ram_data_o); end
    total++; if ({busy_o, done_o, error_o} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy_o, done_o, error_o}); end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_load4();
    logic [7:0] d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int cnt;
    got_addr.delete(); got_data.delete();
    send_byte(8'hA5);
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL load4_busy got=%b exp=1", busy_o); end
    send_byte(8'h00); send_byte(8'h04);
    for (int i = 0; i < 4; i++) begin send_byte(d[i]); idle(i); end
    send_byte(8'h56);
    cnt = 0;
    while (cpu_reset_o === 1'b1 && cnt < RD + 20) begin @(negedge clk); cnt++; end
    total++; if (cnt !== RD) begin bad++; $display("FAIL load4_release_delay got=%0d exp=%0d", cnt, RD); end
    total++; if ({done_o, busy_o, error_o} !== 3'b100) begin bad++; $display("FAIL load4_flags got=%b exp=100", {done_o, busy_o, error_o}); end
    total++; if (got_addr.size() !== 4) begin bad++; $display("FAIL load4_wcount got=%0d exp=4", got_addr.size()); end
    else for (int i = 0; i < 4; i++) begin
      total++;
      if (got_addr[i] !== 16'(LS + i) || got_data[i] !== d[i]) begin
        bad++; $display("FAIL load4_write%0d got=%h:%h exp=%h:%h", i, got_addr[i], got_data[i], 16'(LS + i), d[i]);
      end
    end
  endtask

  task automatic test_run_bytes();
    send_byte(8'h41);
    idle(2);
    total++; if (cpu_reset_o !== 1'b0 || done_o !== 1'b1) begin bad++; $display("FAIL run_noise got=%b%b exp=01", cpu_reset_o, done_o); end
  endtask

  task automatic test_bad_csum();
    int cnt;
    got_addr.delete(); got_data.delete();
    send_byte(8'hA5);
    total++; if (cpu_reset_o !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("FAIL bad_restart got=%b%b exp=11", cpu_reset_o, busy_o); end
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
    total++; if (error_o !== 1'b1 || cpu_reset_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      bad++; $display("FAIL bad_csum_flags got=e%b r%b b%b d%b exp=e1 r1 b0 d0", error_o, cpu_reset_o, busy_o, done_o);
    end
    idle(RD + 5);
    total++; if (cpu_reset_o !== 1'b1) begin bad++; $display("FAIL bad_csum_held got=%b exp=1", cpu_reset_o); end
    total++; if (got_addr.size() !== 2) begin bad++; $display("FAIL bad_csum_wcount got=%0d exp=2", got_addr.size()); end
    // Following good frame clears the sticky error and loads.
    send_byte(8'hA5);
    total++; if (error_o !== 1'b0) begin bad++; $display("FAIL recover_err_clear got=%b exp=0", error_o); end
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h80); send_byte(8'h80);
    cnt = 0;
    while (cpu_reset_o === 1'b1 && cnt < RD + 20) begin @(negedge clk); cnt++; end
    total++; if (cnt !== RD || done_o !== 1'b1) begin bad++; $display("FAIL recover_release got=%0d/%b exp=%0d/1", cnt, done_o, RD); end
  endtask

  task automatic test_oversize();
    got_addr.delete(); got_data.delete();
    send_byte(8'hA5); send_byte(8'h0F); send_byte(8'h00);
    total++; if (error_o !== 1'b1 || cpu_reset_o !== 1'b1) begin bad++; $display("FAIL oversize_err got=%b%b exp=11", error_o, cpu_reset_o); end
    send_byte(8'h12); send_byte(8'h34);
    idle(3);
    total++; if (got_addr.size() !== 0) begin bad++; $display("FAIL oversize_writes got=%0d exp=0", got_addr.size()); end
  endtask

  task automatic test_zero_len();
    int cnt;
    got_addr.delete(); got_data.delete();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    cnt = 0;
    while (cpu_reset_o === 1'b1 && cnt < RD + 20) begin @(negedge clk); cnt++; end
    total++; if (cnt !== RD || done_o !== 1'b1 || error_o !== 1'b0) begin bad++; $display("FAIL zero_len got=%0d d%b e%b exp=%0d d1 e0", cnt, done_o, error_o, RD); end
    total++; if (got_addr.size() !== 0) begin bad++; $display("FAIL zero_len_writes got=%0d exp=0", got_addr.size()); end
  endtask

  task automatic test_timeout();
    int cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h08);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    cnt = 0;
    while (error_o !== 1'b1 && cnt < TO + 20) begin @(negedge clk); cnt++; end
    total++; if (cnt !== TO) begin bad++; $display("FAIL timeout_cycles got=%0d exp=%0d", cnt, TO); end
    total++; if (busy_o !== 1'b0 || cpu_reset_o !== 1'b1) begin bad++; $display("FAIL timeout_flags got=b%b r%b exp=b0 r1", busy_o, cpu_reset_o); end
  endtask

  task automatic test_boundary();
    int cnt;
    int s;
    logic [7:0] b;
    logic [15:0] lw;
    got_addr.delete(); got_data.delete();
    s = 0;
    send_byte(8'hA5); send_byte(8'(MAXLEN >> 8)); send_byte(8'(MAXLEN));
    for (int i = 0; i < MAXLEN; i++) begin b = 8'($urandom); s += int'(b); send_byte(b); end
    send_byte(8'(256 - (s % 256)));
    cnt = 0;
    while (cpu_reset_o === 1'b1 && cnt < RD + 20) begin @(negedge clk); cnt++; end
    total++; if (cnt !== RD) begin bad++; $display("FAIL maxlen_release got=%0d exp=%0d", cnt, RD); end
    total++; if (got_addr.size() !== MAXLEN) begin bad++; $display("FAIL maxlen_wcount got=%0d exp=%0d", got_addr.size(), MAXLEN); end
    else begin
      lw = got_addr[MAXLEN - 1];
      total++; if (lw !== 16'(RS - 7)) begin bad++; $display("FAIL maxlen_last_addr got=%h exp=%h", lw, 16'(RS - 7)); end
    end
    got_addr.delete(); got_data.delete();
    send_byte(8'hA5); send_byte(8'((MAXLEN + 1) >> 8)); send_byte(8'(MAXLEN + 1));
    total++; if (error_o !== 1'b1) begin bad++; $display("FAIL maxlen_plus1_err got=%b exp=1", error_o); end
    idle(2);
    total++; if (got_addr.size() !== 0) begin bad++; $display("FAIL maxlen_plus1_writes got=%0d exp=0", got_addr.size()); end
  endtask

  task automatic test_random();
    int len, s, cnt, k;
    for (int n = 0; n < 16; n++) begin
      frame_q.delete();
      k = $urandom_range(0, 7);
      len = (k == 0) ? MAXLEN + 1 + $urandom_range(0, 2000) : $urandom_range(0, 24);
      frame_q.push_back(8'hA5);
      frame_q.push_back(8'(len >> 8));
      frame_q.push_back(8'(len));
      if (len <= MAXLEN) begin
        s = 0;
        for (int i = 0; i < len; i++) begin frame_q.push_back(8'($urandom)); s += int'(frame_q[3 + i]); end
        frame_q.push_back(8'(256 - (s % 256) + ((k == 1) ? $urandom_range(1, 255) : 0)));
      end
      model();
      // Non-magic noise between frames must be ignored.
      send_byte(8'($urandom_range(0, 255)) == 8'hA5 ? 8'h5A : 8'($urandom_range(0, 255)));
      idle(1);
      got_addr.delete(); got_data.delete();
      foreach (frame_q[i]) begin send_byte(frame_q[i]); if (i != frame_q.size() - 1) idle($urandom_range(0, 3)); end
      if (exp_pass) begin
        cnt = 0;
        while (cpu_reset_o === 1'b1 && cnt < RD + 20) begin @(negedge clk); cnt++; end
        total++; if (cnt !== RD || done_o !== 1'b1 || error_o !== 1'b0) begin
          bad++; $display("FAIL rand%0d_pass got=%0d d%b e%b exp=%0d d1 e0", n, cnt, done_o, error_o, RD);
        end
      end else begin
        total++; if (error_o !== 1'b1 || cpu_reset_o !== 1'b1 || done_o !== 1'b0) begin
          bad++; $display("FAIL rand%0d_fail got=e%b r%b d%b exp=e1 r1 d0", n, error_o, cpu_reset_o, done_o);
        end
      end
      idle(2);
      total++; if (got_addr.size() !== exp_addr.size()) begin
        bad++; $display("FAIL rand%0d_wcount got=%0d exp=%0d", n, got_addr.size(), exp_addr.size());
      end else begin
        foreach (exp_addr[i]) begin
          total++;
          if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
            bad++; $display("FAIL rand%0d_write%0d got=%h:%h exp=%h:%h", n, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_data();
    send_byte(8'hA5);
    total++; if (cpu_reset_o !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("FAIL mid_restart got=%b%b exp=11", cpu_reset_o, busy_o); end
    send_byte(8'h00); send_byte(8'h08); send_byte(8'hDE); send_byte(8'hAD);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if ({ram_we_o, ram_addr_o, ram_data_o} !== 25'h0) begin bad++; $display("FAIL mid_reset_ram got=%b %h %h exp=0 0 0", ram_we_o, ram_addr_o, ram_data_o); end
    total++; if ({cpu_reset_o, busy_o, done_o, error_o} !== 4'b1000) begin bad++; $display("FAIL mid_reset_flags got=%b exp=1000", {cpu_reset_o, busy_o, done_o, error_o}); end
    // Remaining bytes of the aborted frame are ignored in WAIT_MAGIC.
    send_byte(8'h01); send_byte(8'h02);
    idle(2);
    total++; if (busy_o !== 1'b0 || ram_we_o !== 1'b0) begin bad++; $display("FAIL mid_reset_idle got=b%b w%b exp=b0 w0", busy_o, ram_we_o); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load4();
    test_run_bytes();
    test_bad_csum();
    test_oversize();
    test_zero_len();
    test_timeout();
    test_boundary();
    test_random();
    test_load4();
    test_reset_mid_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
